// File: rtl/rpn_stack_sequencer.sv
// Purpose: drives an external operand Stack from a stream of postfix tokens and reports the final value.
// Latency: operand busy 1 cycle, operator busy 5 cycles, final pop adds 3 cycles before result_valid.
// Backpressure: tok_ready is high only in IDLE; an error parks the block until rstn.
module rpn_stack_sequencer #(
    parameter int DEPTH     = 8,
    parameter int BANDWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 tok_valid,
    output logic                 tok_ready,
    input  logic                 tok_is_op,
    input  logic                 tok_last,
    input  logic [BANDWIDTH-1:0] tok_data,
    output logic                 stk_push,
    output logic                 stk_pop,
    output logic [BANDWIDTH-1:0] stk_data,
    input  logic [BANDWIDTH-1:0] stk_top,
    output logic [BANDWIDTH-1:0] result,
    output logic                 result_valid,
    output logic                 error
);

    localparam int DW = $clog2(DEPTH) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_PUSH, S_POPB, S_CAPB, S_POPA, S_CAPA,
        S_PUSHR, S_FIN, S_FPOP, S_FCAP, S_ERR
    } state_t;

    state_t               state, state_nxt;
    logic [DW-1:0]        depth;
    logic                 last_q;
    logic [1:0]           opcode;
    logic [BANDWIDTH-1:0] opb;
    logic [BANDWIDTH-1:0] alu_res;
    logic                 accept;

    assign accept = tok_valid && tok_ready;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and Moore outputs towards the token source and the Stack.
    always_comb begin
        state_nxt = state;
        tok_ready = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE: begin
                tok_ready = 1'b1;
                if (accept) begin
                    if (tok_is_op) state_nxt = (depth < DW'(2))      ? S_ERR : S_POPB;
                    else           state_nxt = (depth == DW'(DEPTH)) ? S_ERR : S_PUSH;
                end
            end
            S_PUSH: begin
                stk_push  = 1'b1;
                state_nxt = last_q ? S_FIN : S_IDLE;
            end
            S_POPB: begin
                stk_pop   = 1'b1;
                state_nxt = S_CAPB;
            end
            S_CAPB:  state_nxt = S_POPA;
            S_POPA: begin
                stk_pop   = 1'b1;
                state_nxt = S_CAPA;
            end
            S_CAPA:  state_nxt = S_PUSHR;
            S_PUSHR: begin
                stk_push  = 1'b1;
                state_nxt = last_q ? S_FIN : S_IDLE;
            end
            S_FIN:   state_nxt = (depth != DW'(1)) ? S_ERR : S_FPOP;
            S_FPOP: begin
                stk_pop   = 1'b1;
                state_nxt = S_FCAP;
            end
            S_FCAP:  state_nxt = S_IDLE;
            S_ERR:   error = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operator evaluation; stk_top carries the deeper operand (opa) during CAPA.
    always_comb begin
        alu_res = '0;
        case (opcode)
            2'b00:   alu_res = stk_top + opb;
            2'b01:   alu_res = stk_top - opb;
            2'b10:   alu_res = stk_top * opb;
            default: alu_res = stk_top ^ opb;
        endcase
    end

    // Token latches, operand capture and occupancy tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            depth    <= '0;
            last_q   <= 1'b0;
            opcode   <= 2'b00;
            opb      <= '0;
            stk_data <= '0;
        end else begin
            if (accept) begin
                last_q <= tok_last;
                if (tok_is_op) opcode   <= tok_data[1:0];
                else           stk_data <= tok_data;
            end
            if (state == S_CAPB) opb      <= stk_top;
            if (state == S_CAPA) stk_data <= alu_res;
            if (state == S_FCAP)  depth <= '0;
            else if (stk_push)    depth <= depth + DW'(1);
            else if (stk_pop)     depth <= depth - DW'(1);
        end
    end

    // Result register and its pulse update together so result is already new while result_valid is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= (state == S_FCAP);
            if (state == S_FCAP) result <= stk_top;
        end
    end

endmodule
